// File: rtl/ysyx_22041211_wbu_pipe.sv
// Writeback/commit unit: in-order commit FIFO, late load-data merge and one
// registered commit (GPR + CSR write) per retired instruction.
module ysyx_22041211_wbu_pipe #(
  parameter int DATA_LEN = 32,
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_pc,
  input  logic                in_wd,
  input  logic [REG_AW-1:0]   in_wreg,
  input  logic [DATA_LEN-1:0] in_wdata,
  input  logic                in_is_mem,
  input  logic                in_csr_we,
  input  logic [11:0]         in_csr_addr,
  input  logic [DATA_LEN-1:0] in_csr_wdata,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [DATA_LEN-1:0] lsu_rdata,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_LEN-1:0] rf_wdata,
  output logic                csr_we,
  output logic [11:0]         csr_waddr,
  output logic [DATA_LEN-1:0] csr_wdata,
  output logic                commit_valid,
  output logic [DATA_LEN-1:0] commit_pc,
  output logic [63:0]         retired_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [DATA_LEN-1:0] pc;
    logic                wd;
    logic [REG_AW-1:0]   wreg;
    logic [DATA_LEN-1:0] wdata;
    logic                is_mem;
    logic                csr_we;
    logic [11:0]         csr_addr;
    logic [DATA_LEN-1:0] csr_wdata;
  } entry_t;

  typedef enum logic [1:0] {
    HEAD_EMPTY    = 2'd0,
    HEAD_WAIT_MEM = 2'd1,
    HEAD_READY    = 2'd2
  } head_state_t;

  entry_t      fifo_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;

  entry_t      in_entry_s;
  entry_t      head_s;
  head_state_t head_state_s;
  logic        push_s;
  logic        pop_s;

  assign in_entry_s = '{pc: in_pc, wd: in_wd, wreg: in_wreg, wdata: in_wdata,
                        is_mem: in_is_mem, csr_we: in_csr_we,
                        csr_addr: in_csr_addr, csr_wdata: in_csr_wdata};
  assign head_s     = fifo_r[rd_ptr_r];

  // No bypass: a full FIFO stalls upstream even if the head retires this cycle.
  assign in_ready  = (count_r != (PW+1)'(DEPTH));
  assign lsu_ready = (head_state_s == HEAD_WAIT_MEM);
  assign push_s    = in_valid && in_ready;

  // Head classification and pop decision
  always_comb begin
    head_state_s = HEAD_EMPTY;
    pop_s        = 1'b0;
    if (count_r == {(PW+1){1'b0}}) begin
      head_state_s = HEAD_EMPTY;
    end else if (head_s.is_mem) begin
      head_state_s = HEAD_WAIT_MEM;
    end else begin
      head_state_s = HEAD_READY;
    end
    case (head_state_s)
      HEAD_READY:    pop_s = 1'b1;
      HEAD_WAIT_MEM: pop_s = lsu_valid;
      default:       pop_s = 1'b0;
    endcase
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= in_entry_s;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1'b1);
        2'b01:   count_r <= count_r - (PW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered commit outputs; write ports are zeroed outside commit pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_valid <= 1'b0;
      commit_pc    <= {DATA_LEN{1'b0}};
      rf_we        <= 1'b0;
      rf_waddr     <= {REG_AW{1'b0}};
      rf_wdata     <= {DATA_LEN{1'b0}};
      csr_we       <= 1'b0;
      csr_waddr    <= 12'd0;
      csr_wdata    <= {DATA_LEN{1'b0}};
      retired_cnt  <= 64'd0;
    end else if (pop_s) begin
      commit_valid <= 1'b1;
      commit_pc    <= head_s.pc;
      rf_we        <= head_s.wd && (head_s.wreg != {REG_AW{1'b0}});
      rf_waddr     <= head_s.wreg;
      rf_wdata     <= head_s.is_mem ? lsu_rdata : head_s.wdata;
      csr_we       <= head_s.csr_we;
      csr_waddr    <= head_s.csr_addr;
      csr_wdata    <= head_s.csr_wdata;
      retired_cnt  <= retired_cnt + 64'd1;
    end else begin
      commit_valid <= 1'b0;
      commit_pc    <= {DATA_LEN{1'b0}};
      rf_we        <= 1'b0;
      rf_waddr     <= {REG_AW{1'b0}};
      rf_wdata     <= {DATA_LEN{1'b0}};
      csr_we       <= 1'b0;
      csr_waddr    <= 12'd0;
      csr_wdata    <= {DATA_LEN{1'b0}};
      retired_cnt  <= retired_cnt;
    end
  end

endmodule

// File: doc/ysyx_22041211_wbu_pipe.md
# ysyx_22041211_wbu_pipe

Parametrised writeback/commit unit for the ysyx_22041211 core. It buffers completed instructions from EXU/LSU in an in-order FIFO and merges late load data from the LSU. It drives one register-file write, one CSR write and a one-cycle commit pulse per retired instruction. It replaces the fixed-state writeback FSM with valid/ready handshakes, configurable buffering, sustained one-commit-per-cycle throughput and a retire counter.

## Interface
- DATA_LEN, 32, data width of GPR/CSR write data and PC
- REG_AW, 5, GPR address width
- DEPTH, 2, commit FIFO entries; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  upstream entry valid
- in_ready  out  1  FIFO can accept (= !full)
- in_pc  in  DATA_LEN  PC of instruction
- in_wd  in  1  instruction writes GPR
- in_wreg  in  REG_AW  destination GPR
- in_wdata  in  DATA_LEN  ALU result (ignored when in_is_mem)
- in_is_mem  in  1  load/store; waits for LSU response
- in_csr_we  in  1  instruction writes CSR
- in_csr_addr  in  12  CSR address
- in_csr_wdata  in  DATA_LEN  CSR write data
- lsu_valid  in  1  LSU response valid; held until lsu_ready
- lsu_ready  out  1  head entry accepts LSU response
- lsu_rdata  in  DATA_LEN  load data
- rf_we / rf_waddr / rf_wdata  out  1 / REG_AW / DATA_LEN  GPR write port
- csr_we / csr_waddr / csr_wdata  out  1 / 12 / DATA_LEN  CSR write port
- commit_valid  out  1  one-cycle pulse per retired instruction
- commit_pc  out  DATA_LEN  PC of retired instruction
- retired_cnt  out  64  retired-instruction count

## Operation
- FIFO: wr_ptr, rd_ptr, count of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
- Push when in_valid && in_ready; all in_* fields are stored.
- No bypass: in_ready = (count != DEPTH), even when a pop occurs in the same cycle.
- The head entry state is derived from the FIFO:
  - HEAD_EMPTY: count==0.
  - HEAD_WAIT_MEM: head is_mem, response not yet taken.
  - HEAD_READY: head !is_mem.
- lsu_ready = (head state == HEAD_WAIT_MEM). LSU responses are strictly in order. lsu_valid while lsu_ready=0 is ignored.
- Pop (commit) when HEAD_READY, or when HEAD_WAIT_MEM and lsu_valid && lsu_ready. A load commits in its handshake cycle, with data taken from lsu_rdata.
- Commit registers the following on the edge ending the pop cycle:
  - commit_valid=1, commit_pc=head pc.
  - rf_we = head wd && wreg!=0; rf_waddr=head wreg.
  - rf_wdata = is_mem ? lsu_rdata : head wdata.
  - csr_we/csr_waddr/csr_wdata = head csr fields.
- Non-commit cycles: commit_valid, rf_we and csr_we are 0; address/data outputs are 0.
- A store (is_mem, wd=0) commits with rf_we=0 after its LSU handshake.
- retired_cnt increments by 1 on every commit and wraps at 2^64.
- Simultaneous push and pop: count unchanged, both pointers advance.

## Timing
- Reset:
  - All outputs 0 except in_ready=1.
  - FIFO empty, retired_cnt=0.
  - rst mid-operation drops all buffered entries; no commit pulse for them.
- Non-mem latency: accepted at cycle T → head at T+1 → commit outputs visible at T+2.
- Load latency: LSU handshake at cycle L → outputs visible at L+1.
- Throughput: one commit per cycle with a non-mem stream; DEPTH≥2 sustains in_ready=1 at full rate.
- Write-port outputs are valid only while commit_valid=1; each pulse is exactly one cycle.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1 → all outputs 0, in_ready=1, retired_cnt=0, no commits.
- ALU op accepted at cycle 1 (pc=0x80000000, wreg=5, wdata=0x1234, wd=1) → cycle 3: commit_valid=1, rf_we=1, rf_waddr=5, rf_wdata=0x1234, commit_pc=0x80000000; cycle 4: commit_valid=0; retired_cnt=1.
- Write to x0 (wreg=0, wd=1) plus CSR write (csr_addr=0x305, csr_wdata=0x80000100) → commit_valid=1, rf_we=0, csr_we=1, csr_waddr=0x305, csr_wdata=0x80000100.
- Load (is_mem=1, wreg=7) followed by 2 ALU ops, DEPTH=2; lsu_valid held low for 5 cycles:
  - lsu_ready=1 throughout the wait.
  - in_ready=0 once 2 entries are buffered.
  - lsu_valid with rdata=0xDEADBEEF → next cycle rf_waddr=7, rf_wdata=0xDEADBEEF.
  - The ALU ops then commit in order on consecutive cycles.
- 8 back-to-back ALU ops with in_valid held high → 8 consecutive commit_valid pulses in PC order, in_ready never drops, retired_cnt=8.
- Assert rst while 2 entries are buffered and a load is pending → no commit_valid afterwards, lsu_ready=0, in_ready=1, retired_cnt=0.
